// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit of the 5-stage RV32I pipeline.
// It turns MemRead/MemWrite, funct3 and the ALU address into one req/gnt/rvalid
// transaction on the data bus. Load data is aligned, extended and registered.
// Latency: a store takes 3 or more cycles (IDLE, REQ, DONE). A load takes 4 or
// more cycles (IDLE, REQ, RESP, DONE).
// Backpressure: stall holds IF..MEM for the whole transaction and drops for
// exactly one cycle in DONE. Misaligned accesses never stall and never reach the bus.
// Ports: clk/rst (async active-low); EX/MEM inputs mem_read_i, mem_write_i,
// funct3_i, addr_i, store_data_i; data bus dbus_*; loaddata_o to MEM/WB;
// stall_o, misalign_o, bus_err_o.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT     = 255,
    parameter bit          ZERO_ON_ERR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_be_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_gnt_i,
    input  logic        dbus_rvalid_i,
    input  logic [31:0] dbus_rdata_i,
    output logic [31:0] loaddata_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        bus_err_o
);
    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    off;
    logic [2:0]    f3;

    logic        is_byte, is_half, access, misalign, start, tmo;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt, lane, ext;

    // The size comes from funct3[1:0] alone. The undefined codes 011/110/111
    // therefore decode as a word, and so does store size 11.
    assign is_byte    = (funct3_i[1:0] == 2'b00);
    assign is_half    = (funct3_i[1:0] == 2'b01);
    assign access     = mem_read_i | mem_write_i;
    assign misalign   = (is_half & addr_i[0]) |
                        (!is_byte & !is_half & (addr_i[1:0] != 2'b00));
    assign misalign_o = access & misalign;

    // Gate on rst so that stall drops at once while reset is held, even if
    // the EX/MEM register still presents an access.
    assign start   = rst & (state == IDLE) & access & !misalign;
    assign stall_o = start | (state == REQ) | (state == RESP);

    // The counter runs from 0 on the first cycle of REQ or RESP. The abort
    // therefore fires on the cycle that holds count TIMEOUT-1, which is the
    // TIMEOUT-th cycle spent waiting.
    assign tmo = (TIMEOUT != 0) && (cnt == CNT_LAST);

    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = store_data_i;
        if (is_byte) begin
            be_nxt    = 4'b0001 << addr_i[1:0];
            wdata_nxt = {4{store_data_i[7:0]}};
        end else if (is_half) begin
            be_nxt    = 4'b0011 << addr_i[1:0];
            wdata_nxt = {2{store_data_i[15:0]}};
        end
    end

    // Move the addressed byte or halfword down to bit 0, then extend it.
    assign lane = dbus_rdata_i >> {off, 3'b000};

    always_comb begin
        case (f3)
            3'b000:  ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  ext = {24'b0, lane[7:0]};
            3'b101:  ext = {16'b0, lane[15:0]};
            default: ext = lane;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            off          <= 2'b00;
            f3           <= 3'b000;
            dbus_req_o   <= 1'b0;
            dbus_we_o    <= 1'b0;
            dbus_addr_o  <= '0;
            dbus_be_o    <= '0;
            dbus_wdata_o <= '0;
            loaddata_o   <= '0;
            bus_err_o    <= 1'b0;
        end else begin
            bus_err_o <= 1'b0;
            cnt       <= cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= REQ;
                        cnt          <= '0;
                        dbus_req_o   <= 1'b1;
                        // If a load and a store are flagged together, the store wins.
                        dbus_we_o    <= mem_write_i;
                        dbus_addr_o  <= {addr_i[31:2], 2'b00};
                        dbus_be_o    <= be_nxt;
                        dbus_wdata_o <= wdata_nxt;
                        off          <= addr_i[1:0];
                        f3           <= funct3_i;
                    end
                end
                REQ: begin
                    if (dbus_gnt_i) begin
                        dbus_req_o <= 1'b0;
                        cnt        <= '0;
                        state      <= dbus_we_o ? DONE : RESP;
                    end else if (tmo) begin
                        dbus_req_o <= 1'b0;
                        bus_err_o  <= 1'b1;
                        if (ZERO_ON_ERR) loaddata_o <= '0;
                        state      <= DONE;
                    end
                end
                RESP: begin
                    if (dbus_rvalid_i) begin
                        loaddata_o <= ext;
                        state      <= DONE;
                    end else if (tmo) begin
                        bus_err_o  <= 1'b1;
                        if (ZERO_ON_ERR) loaddata_o <= '0;
                        state      <= DONE;
                    end
                end
                default: state <= IDLE;   // DONE: one free cycle, no new access
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        dbus_req, dbus_we;
    logic [31:0] dbus_addr, dbus_wdata;
    logic [3:0]  dbus_be;
    logic        dbus_gnt, dbus_rvalid;
    logic [31:0] dbus_rdata;
    logic [31:0] loaddata;
    logic        stall, misalign, bus_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_be;
    logic        seen_we, mis_seen;
    int          stall_cycles, req_cycles;

    mem_stage_lsu #(.TIMEOUT(4), .ZERO_ON_ERR(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read_i   (mem_read),
        .mem_write_i  (mem_write),
        .funct3_i     (funct3),
        .addr_i       (addr),
        .store_data_i (store_data),
        .dbus_req_o   (dbus_req),
        .dbus_we_o    (dbus_we),
        .dbus_addr_o  (dbus_addr),
        .dbus_be_o    (dbus_be),
        .dbus_wdata_o (dbus_wdata),
        .dbus_gnt_i   (dbus_gnt),
        .dbus_rvalid_i(dbus_rvalid),
        .dbus_rdata_i (dbus_rdata),
        .loaddata_o   (loaddata),
        .stall_o      (stall),
        .misalign_o   (misalign),
        .bus_err_o    (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one access, act as a bus slave and stop once stall drops.
    // The slave grants in the first REQ cycle unless no_gnt is set, and it
    // returns rdat in the cycle after a read grant.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] sd,
                              input logic [31:0] rdat, input logic no_gnt);
        logic pend;
        int   n;
        @(negedge clk);
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
        #1;
        mis_seen = misalign;
        stall_cycles = 0; req_cycles = 0; pend = 1'b0; n = 0;
        while (stall && n < 20) begin
            stall_cycles++;
            if (dbus_req) begin
                req_cycles++;
                seen_addr = dbus_addr; seen_be = dbus_be;
                seen_wdata = dbus_wdata; seen_we = dbus_we;
            end
            dbus_gnt    = dbus_req & !no_gnt;
            dbus_rvalid = pend;
            dbus_rdata  = pend ? rdat : 32'h0;
            pend        = dbus_req & !no_gnt & !dbus_we;
            @(negedge clk); #1;
            n++;
        end
        chk("stall_bound", (n < 20) ? 32'd1 : 32'd0, 32'd1);
        // The DUT now sits in DONE, or still in IDLE if the access was misaligned.
        dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
    endtask

    task automatic idle_inputs();
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    initial begin
        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b0;
        addr = '0; store_data = '0; dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_req", {31'b0, dbus_req}, 32'd0);
        chk("rst_we", {31'b0, dbus_we}, 32'd0);
        chk("rst_addr", dbus_addr, 32'd0);
        chk("rst_be", {28'b0, dbus_be}, 32'd0);
        chk("rst_wdata", dbus_wdata, 32'd0);
        chk("rst_load", loaddata, 32'd0);
        chk("rst_err", {31'b0, bus_err}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        rst = 1'b1;

        // LW 0x100
        run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0);
        chk("lw_addr", seen_addr, 32'h100);
        chk("lw_be", {28'b0, seen_be}, 32'hF);
        chk("lw_we", {31'b0, seen_we}, 32'd0);
        chk("lw_stall", stall_cycles, 32'd3);
        chk("lw_data", loaddata, 32'hDEADBEEF);
        chk("lw_err", {31'b0, bus_err}, 32'd0);
        idle_inputs();

        // LB and LBU at 0x103
        run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 1'b0);
        chk("lb_mis", {31'b0, mis_seen}, 32'd0);
        chk("lb_be", {28'b0, seen_be}, 32'h8);
        chk("lb_data", loaddata, 32'hFFFFFF80);
        idle_inputs();
        run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 1'b0);
        chk("lbu_data", loaddata, 32'h00000080);
        idle_inputs();

        // SH 0x202
        run_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 1'b0);
        chk("sh_addr", seen_addr, 32'h200);
        chk("sh_be", {28'b0, seen_be}, 32'hC);
        chk("sh_wdata", seen_wdata, 32'hABCDABCD);
        chk("sh_we", {31'b0, seen_we}, 32'd1);
        chk("sh_stall", stall_cycles, 32'd2);
        chk("sh_load_kept", loaddata, 32'h00000080);
        idle_inputs();

        // Read and write flagged together act as SB 0x201
        run_access(1'b1, 1'b1, 3'b000, 32'h201, 32'h12345678, 32'h0, 1'b0);
        chk("sb_be", {28'b0, seen_be}, 32'h2);
        chk("sb_wdata", seen_wdata, 32'h78787878);
        chk("sb_we", {31'b0, seen_we}, 32'd1);
        idle_inputs();

        // Misaligned LW 0x101
        run_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1'b0);
        chk("mis_flag", {31'b0, mis_seen}, 32'd1);
        chk("mis_stall", stall_cycles, 32'd0);
        chk("mis_req", req_cycles, 32'd0);
        chk("mis_load_kept", loaddata, 32'h00000080);
        idle_inputs();

        // LH and LHU at 0x102
        run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80011234, 1'b0);
        chk("lh_be", {28'b0, seen_be}, 32'hC);
        chk("lh_data", loaddata, 32'hFFFF8001);
        idle_inputs();
        run_access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80011234, 1'b0);
        chk("lhu_data", loaddata, 32'h00008001);
        idle_inputs();

        // funct3 011 is treated as a word load
        run_access(1'b1, 1'b0, 3'b011, 32'h104, 32'h0, 32'h76543210, 1'b0);
        chk("f011_be", {28'b0, seen_be}, 32'hF);
        chk("f011_data", loaddata, 32'h76543210);
        idle_inputs();

        // Timeout: the bus never grants
        run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 1'b1);
        chk("tmo_req_cycles", req_cycles, 32'd4);
        chk("tmo_req_low", {31'b0, dbus_req}, 32'd0);
        chk("tmo_err", {31'b0, bus_err}, 32'd1);
        chk("tmo_data", loaddata, 32'd0);
        idle_inputs();
        @(negedge clk);
        chk("tmo_err_pulse", {31'b0, bus_err}, 32'd0);

        // Reset arriving in RESP
        run_access(1'b1, 1'b0, 3'b010, 32'h108, 32'h0, 32'h11223344, 1'b0);
        chk("pre_rst_data", loaddata, 32'h11223344);
        idle_inputs();
        @(negedge clk);
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h10C;
        @(negedge clk);                 // now in REQ
        dbus_gnt = dbus_req;
        @(negedge clk);                 // now in RESP
        dbus_gnt = 1'b0;
        rst = 1'b0;
        #1;
        chk("rr_req", {31'b0, dbus_req}, 32'd0);
        chk("rr_stall", {31'b0, stall}, 32'd0);
        chk("rr_data", loaddata, 32'd0);
        mem_read = 1'b0;
        dbus_rvalid = 1'b1; dbus_rdata = 32'hCAFEF00D;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        dbus_rvalid = 1'b0;
        chk("rr_late_rvalid", loaddata, 32'd0);
        chk("rr_idle_stall", {31'b0, stall}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
